// File: rtl/cnn_feed_ctrl.sv
// Snapshots the handwriting canvas, streams an IMGxIMG crop to the CNN one pixel per STREAM cycle
// (first pixel registered one cycle after the start edge), then waits for the digit or a timeout.
module cnn_feed_ctrl #(
  parameter int CANVAS  = 30,
  parameter int IMG     = 28,
  parameter int OFS     = 1,
  parameter int PIX_GAP = 0,
  parameter int TIMEOUT = 2000000
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [CANVAS*CANVAS-1:0]   i_canvas,
  output logic [7:0]                 o_pixel,
  output logic                       o_pixel_valid,
  input  logic [3:0]                 i_digit,
  input  logic                       i_digit_valid,
  output logic [3:0]                 o_digit,
  output logic                       o_digit_valid,
  output logic                       o_busy,
  output logic                       o_timeout
);

  localparam int NPIX = CANVAS * CANVAS;
  localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int XW   = (IMG > 1) ? $clog2(IMG) : 1;
  localparam int GW   = (PIX_GAP > 0) ? $clog2(PIX_GAP + 1) : 1;
  localparam int TW   = $clog2(TIMEOUT + 1);

  localparam logic [XW-1:0] XMAX = XW'(IMG - 1);
  localparam logic [GW-1:0] GMAX = GW'((PIX_GAP > 0) ? PIX_GAP - 1 : 0);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, STREAM, GAP, WAIT} state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d, y_q, y_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [NPIX-1:0]   snap_q, snap_d;
  logic [7:0]        pixel_q, pixel_d;
  logic              pixel_vld_q, pixel_vld_d;
  logic [3:0]        digit_q, digit_d;
  logic              digit_vld_q, digit_vld_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;
  logic [IW-1:0]     pix_idx;
  logic              last_pix;

  assign pix_idx  = IW'((int'(y_q) + OFS) * CANVAS + int'(x_q) + OFS);
  assign last_pix = (x_q == XMAX) && (y_q == XMAX);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    gap_d       = gap_q;
    tmo_d       = tmo_q;
    snap_d      = snap_q;
    pixel_d     = 8'h00;
    pixel_vld_d = 1'b0;
    digit_d     = digit_q;
    digit_vld_d = 1'b0;
    timeout_d   = timeout_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          snap_d    = i_canvas;
          x_d       = '0;
          y_d       = '0;
          timeout_d = 1'b0;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        pixel_vld_d = 1'b1;
        pixel_d     = snap_q[pix_idx] ? 8'hFF : 8'h00;
        if (last_pix) begin
          tmo_d   = '0;
          state_d = WAIT;
        end else begin
          if (x_q == XMAX) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          if (PIX_GAP > 0) begin
            gap_d   = '0;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == GMAX) state_d = STREAM;
        else               gap_d   = gap_q + 1'b1;
      end
      WAIT: begin
        // A result arriving on the expiry cycle still wins over the timeout.
        if (i_digit_valid) begin
          digit_d     = i_digit;
          digit_vld_d = 1'b1;
          state_d     = IDLE;
        end else if (tmo_q == TMAX) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      gap_q       <= '0;
      tmo_q       <= '0;
      snap_q      <= '0;
      pixel_q     <= 8'h00;
      pixel_vld_q <= 1'b0;
      digit_q     <= 4'h0;
      digit_vld_q <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      gap_q       <= gap_d;
      tmo_q       <= tmo_d;
      snap_q      <= snap_d;
      pixel_q     <= pixel_d;
      pixel_vld_q <= pixel_vld_d;
      digit_q     <= digit_d;
      digit_vld_q <= digit_vld_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_pixel       = pixel_q;
  assign o_pixel_valid = pixel_vld_q;
  assign o_digit       = digit_q;
  assign o_digit_valid = digit_vld_q;
  assign o_busy        = busy_q;
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_cnn_feed_ctrl.sv
// Randomized bench for cnn_feed_ctrl: two instances (no gap / gap of 2) against a per-cycle timeline model.
module tb_cnn_feed_ctrl;

  localparam int CAN = 30;
  localparam int IMG = 28;
  localparam int OFS = 1;
  localparam int NB  = CAN * CAN;
  localparam int NPX = IMG * IMG;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_v = 1'b0;
  logic          sel = 1'b0;
  logic [NB-1:0] canvas = '0;
  logic [3:0]    dig_in = 4'h0;
  logic          dig_vld_in = 1'b0;

  logic [7:0] pix0, pix2;
  logic       pv0, pv2, dv0, dv2, busy0, busy2, to0, to2;
  logic [3:0] dig0, dig2;

  logic [7:0] m_pix;
  logic       m_pv, m_dv, m_busy, m_to;
  logic [3:0] m_dig;

  int n_chk = 0;
  int n_err = 0;
  logic [3:0] digit_m [2];

  always #20 clk = ~clk;

  cnn_feed_ctrl #(.CANVAS(CAN), .IMG(IMG), .OFS(OFS), .PIX_GAP(0), .TIMEOUT(TMO)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_v & ~sel), .i_canvas(canvas),
    .o_pixel(pix0), .o_pixel_valid(pv0), .i_digit(dig_in), .i_digit_valid(dig_vld_in),
    .o_digit(dig0), .o_digit_valid(dv0), .o_busy(busy0), .o_timeout(to0));

  cnn_feed_ctrl #(.CANVAS(CAN), .IMG(IMG), .OFS(OFS), .PIX_GAP(2), .TIMEOUT(TMO)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_v & sel), .i_canvas(canvas),
    .o_pixel(pix2), .o_pixel_valid(pv2), .i_digit(dig_in), .i_digit_valid(dig_vld_in),
    .o_digit(dig2), .o_digit_valid(dv2), .o_busy(busy2), .o_timeout(to2));

  assign m_pix  = sel ? pix2  : pix0;
  assign m_pv   = sel ? pv2   : pv0;
  assign m_dv   = sel ? dv2   : dv0;
  assign m_busy = sel ? busy2 : busy0;
  assign m_to   = sel ? to2   : to0;
  assign m_dig  = sel ? dig2  : dig0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [NB-1:0] rand_cv();
    logic [NB-1:0] r;
    for (int i = 0; i < NB; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_pv"},   32'(m_pv),   32'd0);
    check_eq({tag, "_pix"},  32'(m_pix),  32'd0);
    check_eq({tag, "_dig"},  32'(m_dig),  32'd0);
    check_eq({tag, "_dv"},   32'(m_dv),   32'd0);
    check_eq({tag, "_busy"}, 32'(m_busy), 32'd0);
    check_eq({tag, "_to"},   32'(m_to),   32'd0);
  endtask

  // Negedge n=0 is the first sample after the start edge; pixel p is expected at n = 1 + p*(gap+1).
  task automatic run(input logic s, input logic [NB-1:0] cv, input logic resp, input int d,
                     input logic [3:0] dval, input logic strays, input int abort_px);
    int gap, n_last, end_n, p, idx, npix;
    logic is_pix, ink;
    gap    = s ? 2 : 0;
    n_last = 1 + (NPX - 1) * (gap + 1);
    end_n  = resp ? n_last + d : n_last + TMO;
    npix   = 0;
    sel    = s;
    canvas = cv;
    @(negedge clk);
    start_v = 1'b1;
    for (int n = 0; n <= end_n + 1; n++) begin
      @(negedge clk);
      start_v    = 1'b0;
      dig_vld_in = 1'b0;
      canvas     = rand_cv();
      if (abort_px >= 0 && n == 1 + abort_px * (gap + 1)) begin
        check_eq("abort_pre_pv", 32'(m_pv), 32'd1);
        #1 rst_n = 1'b0;
        #1 check_idle_outputs("abort");
        digit_m[0] = 4'h0;
        digit_m[1] = 4'h0;
        #5 rst_n = 1'b1;
        return;
      end
      is_pix = (n >= 1) && ((n - 1) % (gap + 1) == 0) && ((n - 1) / (gap + 1) < NPX);
      p      = (n - 1) / (gap + 1);
      ink    = 1'b0;
      if (is_pix) begin
        idx  = (p / IMG + OFS) * CAN + (p % IMG) + OFS;
        ink  = cv[idx];
        npix++;
      end
      check_eq("pix_vld",  32'(m_pv),   32'(is_pix));
      check_eq("pix_val",  32'(m_pix),  ink ? 32'hFF : 32'h00);
      check_eq("busy",     32'(m_busy), 32'(n < end_n));
      check_eq("digit_vld", 32'(m_dv),  32'(resp && n == end_n));
      check_eq("timeout",  32'(m_to),   32'(!resp && n >= end_n));
      check_eq("digit",    32'(m_dig),  32'((resp && n >= end_n) ? dval : digit_m[s]));
      dig_in = 4'($urandom_range(0, 15));
      if (strays && n < n_last - 1 && $urandom_range(0, 49) == 0) dig_vld_in = 1'b1;
      if (strays && n < end_n - 1 && $urandom_range(0, 49) == 0) start_v = 1'b1;
      if (resp && n == n_last + d - 1) begin
        dig_vld_in = 1'b1;
        dig_in     = dval;
      end
    end
    start_v    = 1'b0;
    dig_vld_in = 1'b0;
    check_eq("pix_count", 32'(npix), 32'(NPX));
    if (resp) digit_m[s] = dval;
  endtask

  initial begin
    logic [NB-1:0] cv;
    digit_m[0] = 4'h0;
    digit_m[1] = 4'h0;
    #15;
    sel = 1'b0;
    #1 check_idle_outputs("rst0");
    sel = 1'b1;
    #1 check_idle_outputs("rst2");
    #10 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single ink pixel at canvas (2,2) maps to crop index 29.
    cv = '0;
    cv[62] = 1'b1;
    run(1'b0, cv, 1'b1, 5, 4'd7, 1'b0, -1);
    // Full ink with a two-cycle gap between pixels.
    cv = '1;
    run(1'b1, cv, 1'b1, 3, 4'($urandom_range(0, 15)), 1'b0, -1);
    // No result: timeout, digit keeps 7.
    run(1'b0, rand_cv(), 1'b0, 0, 4'd0, 1'b0, -1);
    // Result on the expiry cycle wins; stray starts/results ignored; timeout cleared.
    run(1'b0, rand_cv(), 1'b1, TMO, 4'($urandom_range(0, 15)), 1'b1, -1);
    run(1'b1, rand_cv(), 1'b0, 0, 4'd0, 1'b1, -1);
    run(1'b1, rand_cv(), 1'b1, 1, 4'($urandom_range(0, 15)), 1'b1, -1);
    // Reset mid-stream, then a full clean run.
    run(1'b0, rand_cv(), 1'b1, 5, 4'd3, 1'b0, 300);
    @(negedge clk);
    check_idle_outputs("post_rst");
    run(1'b0, rand_cv(), 1'b1, 1, 4'($urandom_range(0, 15)), 1'b1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
